// File: rtl/lsu_bus_pkg.sv
// Shared types for the LSU data-memory bridge: FSM state encoding and AXI response codes.
package lsu_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WRESP = 3'd2,
    RD    = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } bridge_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/rdata_align.sv
// Right-aligns a read word on its byte offset so the LSU can sign/zero-extend from lane 0.
module rdata_align (
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  input  logic        i_align,
  output logic [31:0] o_data
);

  logic [4:0] w_shamt;

  assign w_shamt = {i_addr_lo, 3'b000};
  assign o_data  = i_align ? (i_data >> w_shamt) : i_data;

endmodule

// File: rtl/lsu_mem_bridge.sv
// LSU data-memory port to AXI4-Lite master: one AXI transaction per mem_req pulse,
// completed by a single mem_rvalid pulse. All AXI outputs and mem_* outputs are registered.
module lsu_mem_bridge
  import lsu_bus_pkg::*;
#(
  parameter bit ALIGN_RDATA = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_awaddr,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [1:0]  axi_bresp,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [31:0] axi_araddr,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  output logic        bus_err,
  output logic        req_overlap
);

  bridge_state_t r_state;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wmask;
  logic          r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic          r_mem_rvalid;
  logic [31:0]   r_mem_rdata;
  logic          r_bus_err, r_req_overlap;

  logic          w_aw_done, w_w_done;
  logic [31:0]   w_aligned;

  rdata_align u_rdata_align (
    .i_addr_lo (r_addr[1:0]),
    .i_data    (axi_rdata),
    .i_align   (ALIGN_RDATA),
    .o_data    (w_aligned)
  );

  // A channel counts as done once its valid has dropped or is handshaking this cycle.
  assign w_aw_done = ~r_awvalid | axi_awready;
  assign w_w_done  = ~r_wvalid  | axi_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wmask       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_mem_rvalid  <= 1'b0;
      r_mem_rdata   <= '0;
      r_bus_err     <= 1'b0;
      r_req_overlap <= 1'b0;
    end else begin
      r_mem_rvalid <= 1'b0;
      if (mem_req && (r_state != IDLE)) r_req_overlap <= 1'b1;

      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wmask <= mem_wmask;
            if (mem_wen) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD;
            end
          end
        end
        WR: begin
          if (r_awvalid && axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WRESP;
          end
        end
        WRESP: begin
          if (axi_bvalid) begin
            r_bready     <= 1'b0;
            r_mem_rdata  <= '0;
            r_mem_rvalid <= 1'b1;
            if (axi_bresp != OKAY) r_bus_err <= 1'b1;
            r_state      <= DONE;
          end
        end
        RD: begin
          if (axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RDATA;
          end
        end
        RDATA: begin
          if (axi_rvalid) begin
            r_rready     <= 1'b0;
            r_mem_rdata  <= w_aligned;
            r_mem_rvalid <= 1'b1;
            if (axi_rresp != OKAY) r_bus_err <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_mem_rdata <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_rvalid  = r_mem_rvalid;
  assign mem_rdata   = r_mem_rdata;
  assign axi_awvalid = r_awvalid;
  assign axi_awaddr  = r_addr;
  assign axi_wvalid  = r_wvalid;
  assign axi_wdata   = r_wdata;
  assign axi_wstrb   = r_wmask;
  assign axi_bready  = r_bready;
  assign axi_arvalid = r_arvalid;
  assign axi_araddr  = r_addr;
  assign axi_rready  = r_rready;
  assign bus_err     = r_bus_err;
  assign req_overlap = r_req_overlap;

endmodule
